// File: rtl/acc_requant_pkg.sv
// Shared widths and limits for the requantization path.
// The MAC and adder-tree stages reuse these so that product width and clip bounds agree.
package acc_requant_pkg;

    // Default datapath widths
    localparam int DEF_ACC_WIDTH   = 32;
    localparam int DEF_SCALE_WIDTH = 16;
    localparam int DEF_OUT_WIDTH   = 8;
    localparam int DEF_SHIFT_WIDTH = 6;

    // Full-precision width of accumulator * multiplier
    function automatic int prod_width(input int acc_w, input int scale_w);
        return acc_w + scale_w;
    endfunction

    localparam int DEF_PW = prod_width(DEF_ACC_WIDTH, DEF_SCALE_WIDTH);

    // Signed clip bounds for an ow-bit result
    function automatic int sat_hi(input int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int ow);
        return -(1 << (ow - 1));
    endfunction

    localparam int DEF_SAT_HI = sat_hi(DEF_OUT_WIDTH);
    localparam int DEF_SAT_LO = sat_lo(DEF_OUT_WIDTH);

endpackage

// File: rtl/acc_requant_round_sat.sv
// Combinational round/shift and zero-point/clip arithmetic.
// Two independent halves: the top registers rnd_o between them so each half
// sits in its own pipeline stage.
module requant_round_sat
    import acc_requant_pkg::*;
#(
    parameter int PW          = DEF_PW,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH
) (
    input  logic signed [PW-1:0]        prod_i,
    input  logic        [SHIFT_WIDTH-1:0] shift_i,
    output logic signed [PW:0]          rnd_o,
    input  logic signed [PW:0]          rnd_i,
    input  logic signed [OUT_WIDTH-1:0] zp_i,
    output logic signed [OUT_WIDTH-1:0] data_o,
    output logic                        sat_o
);

    localparam logic signed [PW+1:0] V_HI = (PW+2)'(sat_hi(OUT_WIDTH));
    localparam logic signed [PW+1:0] V_LO = (PW+2)'(sat_lo(OUT_WIDTH));

    logic        [31:0] sh;
    logic signed [PW:0] half;
    logic signed [PW:0] sum;
    logic signed [PW+1:0] v;

    // Round-half-up arithmetic shift; shift clamped to PW-1, one guard bit keeps the add exact
    always_comb begin
        sh = 32'(shift_i);
        if (sh > 32'(PW - 1)) begin
            sh = 32'(PW - 1);
        end
        // half = 2^(sh-1) for sh>0, zero for sh=0
        half  = ((PW+1)'(1) << sh) >> 1;
        sum   = {prod_i[PW-1], prod_i} + half;
        rnd_o = sum >>> sh;
    end

    // Add zero point in a width that cannot wrap, then clip to the output range
    always_comb begin
        v      = $signed({rnd_i[PW], rnd_i}) + (PW+2)'(zp_i);
        data_o = v[OUT_WIDTH-1:0];
        sat_o  = 1'b0;
        if (v > V_HI) begin
            data_o = V_HI[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
        end else if (v < V_LO) begin
            data_o = V_LO[OUT_WIDTH-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/acc_requant.sv
// Accumulator requantizer: out = clip(round(acc * scale >> shift) + zp).
// Three-stage pipeline (multiply, round/shift, zero-point/clip) with one global
// advance so every stage moves together or holds together.
module acc_requant
    import acc_requant_pkg::*;
#(
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int SCALE_WIDTH = DEF_SCALE_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_load,
    input  logic [SCALE_WIDTH-1:0] cfg_scale,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic [OUT_WIDTH-1:0]   cfg_zp,
    output logic                   cfg_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACC_WIDTH-1:0]   in_acc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic [15:0]            sat_count,
    input  logic                   sat_clr,
    output logic                   busy
);

    localparam int PW = prod_width(ACC_WIDTH, SCALE_WIDTH);

    // Configuration registers
    logic [SCALE_WIDTH-1:0] scale_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [OUT_WIDTH-1:0]   zp_q;
    logic                   cfg_err_q;
    logic                   cfg_ok;

    // Pipeline: vld_q[0]=S1, vld_q[1]=S2, vld_q[2]=S3
    logic [2:0]             vld_q;
    logic signed [PW-1:0]   prod_d, prod_q;
    logic signed [PW:0]     rnd_d, rnd_q;
    logic [OUT_WIDTH-1:0]   data_d, data_q;
    logic                   sat_d, sat_q;
    logic                   advance;

    // Saturation counter
    logic [15:0]            sat_cnt_d, sat_cnt_q;

    // Any stall comes only from the output side; the whole pipe advances as one
    assign advance   = !vld_q[2] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[2];
    assign busy      = |vld_q;
    assign out_data  = data_q;
    assign out_sat   = sat_q;
    assign cfg_err   = cfg_err_q;
    assign sat_count = sat_cnt_q;

    // Config may only change with an empty pipe and nothing being offered, so
    // every in-flight item sees one consistent set of parameters
    assign cfg_ok = cfg_load && !busy && !in_valid;

    // Full-precision signed product
    assign prod_d = PW'($signed(in_acc)) * PW'($signed(scale_q));

    requant_round_sat #(
        .PW          (PW),
        .SHIFT_WIDTH (SHIFT_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH)
    ) u_round_sat (
        .prod_i  (prod_q),
        .shift_i (shift_q),
        .rnd_o   (rnd_d),
        .rnd_i   (rnd_q),
        .zp_i    (zp_q),
        .data_o  (data_d),
        .sat_o   (sat_d)
    );

    // Latch accepted config; flag a rejected load for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            scale_q   <= SCALE_WIDTH'(1);
            shift_q   <= '0;
            zp_q      <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_load && !cfg_ok;
            if (cfg_ok) begin
                scale_q <= cfg_scale;
                shift_q <= cfg_shift;
                zp_q    <= cfg_zp;
            end
        end
    end

    // Stage registers and valids shift together on advance, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            prod_q <= '0;
            rnd_q  <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else if (advance) begin
            vld_q  <= {vld_q[1:0], in_valid};
            prod_q <= prod_d;
            rnd_q  <= rnd_d;
            data_q <= data_d;
            // Keep the flag clean when a bubble moves into S3
            sat_q  <= sat_d && vld_q[1];
        end
    end

    // Count clipped outputs as they leave; clear has priority, count sticks at max
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (vld_q[2] && out_ready && sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Saturation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

endmodule

// File: tb/tb_acc_requant.sv
// Scoreboard bench for acc_requant: a reference model computes each expected
// output when an input is accepted; a monitor pops and compares on every output transfer.
module tb_acc_requant;

    logic        clk;
    logic        rst;
    logic        cfg_load;
    logic [15:0] cfg_scale;
    logic [5:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;
    logic [15:0] sat_count;
    logic        sat_clr;
    logic        busy;

    acc_requant dut (
        .clk(clk), .rst(rst),
        .cfg_load(cfg_load), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
        .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .sat_count(sat_count), .sat_clr(sat_clr), .busy(busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       s;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_scale, m_shift, m_zp;
    int   exp_cnt;
    int   rdy_mode;
    int   stall_cycles;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the requantization rules
    function automatic exp_t model(input int acc);
        exp_t   e;
        longint p, r, v;
        int     sh;
        p  = longint'(acc) * longint'(m_scale);
        sh = (m_shift > 47) ? 47 : m_shift;
        if (sh > 0) r = (p + (longint'(1) << (sh - 1))) >>> sh;
        else        r = p;
        v = r + longint'(m_zp);
        if (v > 127) begin
            e.d = 8'd127; e.s = 1'b1;
        end else if (v < -128) begin
            e.d = 8'h80;  e.s = 1'b1;
        end else begin
            e.d = 8'(v);  e.s = 1'b0;
        end
        return e;
    endfunction

    // Offer one item, wait (bounded) for acceptance, record its expectation
    task automatic send(input int a);
        int n = 0;
        in_valid = 1'b1;
        in_acc   = a;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        else sb.push_back(model(a));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_cfg(input logic [15:0] sc, input logic [5:0] sh, input logic [7:0] zp, input bit ok);
        cfg_load  = 1'b1;
        cfg_scale = sc;
        cfg_shift = sh;
        cfg_zp    = zp;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        chk("cfg_err_pulse", cfg_err, ok ? 0 : 1);
        if (ok) begin
            m_scale = $signed(sc);
            m_shift = int'(sh);
            m_zp    = $signed(zp);
        end
        @(posedge clk); #1;
        chk("cfg_err_one_cycle", cfg_err, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_scoreboard", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    function automatic int rand_acc();
        case ($urandom_range(0, 2))
            0:       return int'($urandom);
            1:       return int'($urandom_range(0, 2000)) - 1000;
            default: return int'($urandom_range(0, 200000)) - 100000;
        endcase
    endfunction

    initial begin
        exp_t e;
        int   quiet;
        rst = 1'b1; in_valid = 1'b0; in_acc = '0; cfg_load = 1'b0;
        cfg_scale = '0; cfg_shift = '0; cfg_zp = '0; sat_clr = 1'b0;
        out_ready = 1'b1; rdy_mode = 0; stall_cycles = 0;
        m_scale = 1; m_shift = 0; m_zp = 0; exp_cnt = 0;

        fork
            // out_ready driver: 0 always high, 1 random, 2 always low, 3 scripted stall window
            begin
                int scr = 0;
                forever begin
                    @(posedge clk); #1;
                    if (rdy_mode != 3) scr = 0; else scr++;
                    case (rdy_mode)
                        0:       out_ready = 1'b1;
                        1:       out_ready = ($urandom_range(0, 3) != 0);
                        2:       out_ready = 1'b0;
                        default: out_ready = !(scr >= 3 && scr <= 7);
                    endcase
                end
            end
            // Monitor: handshake rule, counter, and in-order data against the scoreboard
            begin
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        chk("in_ready_rule", in_ready, (!out_valid || out_ready) ? 1 : 0);
                        chk("sat_count", sat_count, exp_cnt);
                        if (out_valid && !out_ready) stall_cycles++;
                        if (out_valid && out_ready) begin
                            if (sb.size() == 0) begin
                                chk("unexpected_output", 1, 0);
                            end else begin
                                e = sb.pop_front();
                                chk("out_data", $signed(out_data), $signed(e.d));
                                chk("out_sat", out_sat, e.s);
                            end
                        end
                        if (sat_clr) exp_cnt = 0;
                        else if (out_valid && out_ready && out_sat && exp_cnt < 65535) exp_cnt++;
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Default config, pass-through value and exact latency
        send(100);
        @(negedge clk); chk("lat_c1", out_valid, 0);
        @(negedge clk); chk("lat_c2", out_valid, 0);
        @(negedge clk); chk("lat_c3", out_valid, 1);
        @(posedge clk); #1;
        wait_idle();

        // Clipping both ways, counter, clear
        send(1000);
        send(-1000);
        wait_idle();
        chk("sat_count_two", sat_count, 2);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        @(negedge clk); chk("sat_count_cleared", sat_count, 0);
        @(posedge clk); #1;

        // Scale/shift/zero-point rounding
        do_cfg(16'd3, 6'd2, 8'd10, 1'b1);
        send(5);
        send(-5);
        wait_idle();

        // Back-to-back burst through a stall window
        rdy_mode = 3;
        stall_cycles = 0;
        for (int i = 0; i < 6; i++) send(i * 7 - 20);
        wait_idle();
        chk("stall_occurred", (stall_cycles > 0) ? 1 : 0, 1);
        rdy_mode = 0;

        // Load rejected while busy; then clamped maximum shift
        send(9);
        do_cfg(16'd100, 6'd0, 8'd50, 1'b0);
        wait_idle();
        do_cfg(16'd1, 6'd63, 8'd0, 1'b1);
        send(-1);
        send(12345);
        wait_idle();

        // Reset with three items in flight
        rdy_mode = 2;
        send(1); send(2); send(3);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_flush_out_valid", out_valid, 0);
        chk("rst_flush_busy", busy, 0);
        sb.delete();
        exp_cnt = 0;
        m_scale = 1; m_shift = 0; m_zp = 0;
        rdy_mode = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        chk("no_stale_output", quiet, 0);
        @(posedge clk); #1;

        // Randomized traffic under random back-pressure and configs
        for (int k = 0; k < 5; k++) begin
            logic [5:0] rs;
            rs = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(8, 30));
            do_cfg(16'($urandom), rs, 8'($urandom), 1'b1);
            rdy_mode = 1;
            for (int i = 0; i < 60; i++) begin
                send(rand_acc());
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                if ($urandom_range(0, 29) == 0) begin
                    sat_clr = 1'b1;
                    @(posedge clk); #1;
                    sat_clr = 1'b0;
                end
            end
            wait_idle();
            rdy_mode = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
